// File: rtl/vid_pkg.sv
// vid_pkg: pattern encodings, colour-bar table and default 640x480@60 timing
package vid_pkg;
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_GREY  = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;
  // per-bar {r,g,b} full/zero flags: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][2:0] BAR_RGB = {3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
endpackage

// File: rtl/vid_timing.sv
// vid_timing: h/v raster counters with de, sync windows and frame-boundary strobes
module vid_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             first_o,
  output logic             last_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CNT_W-1:0] HA  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] HL  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VA  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] VL  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  always_comb begin
    h_d = !en_i ? '0 : (h_q == HL) ? '0 : h_q + ONE;
    v_d = !en_i ? '0 : (h_q != HL) ? v_q : (v_q == VL) ? '0 : v_q + ONE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h_o     = h_q;
  assign v_o     = v_q;
  assign de_o    = (h_q < HA) && (v_q < VA);
  assign hs_o    = (h_q >= HS0) && (h_q < HS1);
  assign vs_o    = (v_q >= VS0) && (v_q < VS1);
  assign first_o = (h_q == '0) && (v_q == '0);
  assign last_o  = (h_q == HL) && (v_q == VL);
endmodule

// File: rtl/vid_pattern_gen.sv
// vid_pattern_gen: video timing + four test patterns with registered outputs.
// Define MOVING_BOX_EN to build the bouncing box for pattern 3 (black otherwise).
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8,
  parameter int   CNT_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         pattern_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               frame_start
);
  localparam logic [CNT_W-1:0] BW = CNT_W'(H_ACTIVE / 8);
  localparam logic [CNT_W-1:0] SEVEN = CNT_W'(7);
  logic [CNT_W-1:0] h, v, bar_n;
  logic de_c, hs_c, vs_c, first_c, last_c, grey;
  logic [1:0] pat_q, pat;
  logic [2:0] bar_idx, box_f, f;
  logic [COLOR_W-1:0] r_c, g_c, b_c;
  logic hsync_q, vsync_q, de_q, fs_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  vid_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CNT_W(CNT_W)
  ) u_timing (
    .clk(clk), .rst(rst), .en_i(en),
    .h_o(h), .v_o(v), .de_o(de_c), .hs_o(hs_c), .vs_o(vs_c),
    .first_o(first_c), .last_o(last_c)
  );
  // the selector is sampled at (0,0) and that same pixel already uses it
  assign pat = first_c ? pattern_sel : pat_q;
`ifdef MOVING_BOX_EN
  localparam logic [CNT_W-1:0] XMAX = CNT_W'(H_ACTIVE - 32);
  localparam logic [CNT_W-1:0] YMAX = CNT_W'(V_ACTIVE - 32);
  localparam logic [CNT_W-1:0] SZ   = CNT_W'(32);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  logic [CNT_W-1:0] bx_q, bx_d, by_q, by_d;
  logic dx_q, dx_d, dy_q, dy_d, in_box;
  always_comb begin
    bx_d = dx_q ? bx_q + ONE : bx_q - ONE;
    by_d = dy_q ? by_q + ONE : by_q - ONE;
    dx_d = (bx_d == '0 || bx_d == XMAX) ? ~dx_q : dx_q;
    dy_d = (by_d == '0 || by_d == YMAX) ? ~dy_q : dy_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {bx_q, by_q} <= '0;
      {dx_q, dy_q} <= 2'b11;
    end else if (!en) begin
      {bx_q, by_q} <= '0;
      {dx_q, dy_q} <= 2'b11;
    end else if (last_c) begin
      {bx_q, by_q} <= {bx_d, by_d};
      {dx_q, dy_q} <= {dx_d, dy_d};
    end
  end
  assign in_box = (h >= bx_q) && (h < bx_q + SZ) && (v >= by_q) && (v < by_q + SZ);
  assign box_f  = in_box ? 3'b111 : 3'b001;
`else
  logic v_unused;
  assign v_unused = ^v;
  assign box_f    = 3'b000;
`endif
  assign bar_n   = h / BW;
  assign bar_idx = (bar_n > SEVEN) ? 3'd7 : bar_n[2:0];
  assign f = (pat == PAT_BARS)  ? BAR_RGB[bar_idx] :
             (pat == PAT_CHECK) ? {3{~(h[5] ^ v[5])}} :
             (pat == PAT_BOX)   ? box_f : 3'b000;
  assign grey = (pat == PAT_GREY);
  assign r_c  = grey ? h[COLOR_W-1:0] : {COLOR_W{f[2]}};
  assign g_c  = grey ? h[COLOR_W-1:0] : {COLOR_W{f[1]}};
  assign b_c  = grey ? h[COLOR_W-1:0] : {COLOR_W{f[0]}};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      {de_q, fs_q} <= 2'b00;
      {r_q, g_q, b_q} <= '0;
      pat_q <= PAT_BARS;
    end else if (!en) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      {de_q, fs_q} <= 2'b00;
      {r_q, g_q, b_q} <= '0;
    end else begin
      hsync_q <= hs_c ? HS_POL : ~HS_POL;
      vsync_q <= vs_c ? VS_POL : ~VS_POL;
      de_q    <= de_c;
      fs_q    <= first_c;
      r_q     <= de_c ? r_c : '0;
      g_q     <= de_c ? g_c : '0;
      b_q     <= de_c ? b_c : '0;
      pat_q   <= first_c ? pattern_sel : pat_q;
    end
  end
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb_vid_pattern_gen: directed bench with a reference raster model feeding a scoreboard queue,
// on a reduced 64x40 raster so several frames fit in a short run.
module tb_vid_pattern_gen;
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 40, VFP = 2, VSY = 2, VBP = 3;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam logic [27:0] IDLE = 28'hC000000;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  typedef struct {
    logic [27:0] exp;
    int x;
    int y;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic hsync, vsync, de, frame_start;
  logic [7:0] r, g, b;
  int checks = 0, failures = 0;
  ent_t sb[$];
  int mh = 0, mv = 0, mbx = 0, mby = 0;
  bit mdx = 1, mdy = 1;
  logic [1:0] mpat = 2'd0;
  int n_de, n_hs, n_vs, n_fs;
  logic [27:0] last_o, first_o;
  logic [23:0] obs_rgb [HA][VA];
  logic obs_hs [HT];

  vid_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(8), .CNT_W(12)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] obs();
    return {hsync, vsync, de, r, g, b, frame_start};
  endfunction

  function automatic logic [27:0] model_out(int x, int y, logic [1:0] p);
    logic hs, vs, act;
    logic [23:0] c;
    logic [7:0] gx;
    hs  = !(x >= HA + HFP && x < HA + HFP + HSY);
    vs  = !(y >= VA + VFP && y < VA + VFP + VSY);
    act = (x < HA) && (y < VA);
    gx  = x[7:0];
    c   = 24'h0;
    if (act) begin
      if (p == 2'd0) c = BARS[(x / (HA / 8) > 7) ? 7 : x / (HA / 8)];
      else if (p == 2'd1) c = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'h000000 : 24'hFFFFFF;
      else if (p == 2'd2) c = {gx, gx, gx};
      else begin
`ifdef MOVING_BOX_EN
        c = (x >= mbx && x < mbx + 32 && y >= mby && y < mby + 32) ? 24'hFFFFFF : 24'h0000FF;
`else
        c = 24'h000000;
`endif
      end
    end
    return {hs, vs, act, c, (x == 0 && y == 0)};
  endfunction

  task automatic chk(input string tag, input logic [27:0] obs_v, input logic [27:0] exp_v);
    checks++;
    assert (obs_v === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  task automatic reset_model();
    mh = 0; mv = 0; mbx = 0; mby = 0; mdx = 1; mdy = 1;
  endtask

  task automatic tick();
    ent_t e;
    logic [1:0] p;
    int nb;
    e.x = mh;
    e.y = mv;
    p = (mh == 0 && mv == 0) ? pattern_sel : mpat;
    e.exp = (!rst || !en) ? IDLE : model_out(mh, mv, p);
    sb.push_back(e);
    if (!rst) begin
      mpat = 2'd0;
      reset_model();
    end else if (!en) reset_model();
    else begin
      if (mh == 0 && mv == 0) mpat = pattern_sel;
      if (mh == HT - 1 && mv == VT - 1) begin
        nb = mdx ? mbx + 1 : mbx - 1;
        if (nb == 0 || nb == HA - 32) mdx = !mdx;
        mbx = nb;
        nb = mdy ? mby + 1 : mby - 1;
        if (nb == 0 || nb == VA - 32) mdy = !mdy;
        mby = nb;
      end
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else mh++;
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    last_o = obs();
    chk("cyc", last_o, e.exp);
    if (de) n_de++;
    if (!hsync) n_hs++;
    if (!vsync) n_vs++;
    if (frame_start) n_fs++;
    if (e.x < HA && e.y < VA) obs_rgb[e.x][e.y] = {r, g, b};
    if (e.y == 1) obs_hs[e.x] = hsync;
  endtask

  task automatic run_frame(input int chg_y, input logic [1:0] sel);
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    for (int i = 0; i < HT * VT; i++) begin
      if (mv == chg_y && mh == 0) pattern_sel = sel;
      tick();
      if (i == 0) first_o = last_o;
    end
  endtask

  task automatic frame_stats();
    chk("de_per_frame", 28'(n_de), 28'(HA * VA));
    chk("hs_low_cycles", 28'(n_hs), 28'(HSY * VT));
    chk("vs_low_cycles", 28'(n_vs), 28'(VSY * HT));
    chk("fs_per_frame", 28'(n_fs), 28'd1);
  endtask

  initial begin
    #23;
    chk("reset_idle", obs(), IDLE);
    rst = 1'b1;
    tick();
    tick();
    chk("en_low_idle", last_o, IDLE);
    en = 1'b1;
    run_frame(10, 2'd1);
    chk("first_de_fs", 28'({first_o[25], first_o[0]}), 28'b11);
    frame_stats();
    chk("bar_x0", 28'(obs_rgb[0][5]), 28'hFFFFFF);
    chk("bar_x8", 28'(obs_rgb[8][5]), 28'hFFFF00);
    chk("bar_x63", 28'(obs_rgb[63][5]), 28'h000000);
    chk("bar_after_sel_change", 28'(obs_rgb[32][20]), 28'hFF00FF);
    chk("hs_before", 28'(obs_hs[67]), 28'd1);
    chk("hs_first", 28'(obs_hs[68]), 28'd0);
    chk("hs_last", 28'(obs_hs[75]), 28'd0);
    chk("hs_after", 28'(obs_hs[76]), 28'd1);
    run_frame(10, 2'd2);
    frame_stats();
    chk("check_32_0", 28'(obs_rgb[32][0]), 28'h000000);
    chk("check_0_0", 28'(obs_rgb[0][0]), 28'hFFFFFF);
    run_frame(10, 2'd3);
    frame_stats();
    chk("grey_5", 28'(obs_rgb[5][0]), 28'h050505);
    chk("grey_63", 28'(obs_rgb[63][7]), 28'h3F3F3F);
    for (int i = 0; i < 5000 && !(mv == 10 && mh == 20); i++) tick();
    chk("reach_drop_point", 28'(mv == 10 && mh == 20), 28'd1);
`ifdef MOVING_BOX_EN
    chk("box_3_3", 28'(obs_rgb[3][3]), 28'hFFFFFF);
    chk("box_2_3", 28'(obs_rgb[2][3]), 28'h0000FF);
    chk("box_35_3", 28'(obs_rgb[35][3]), 28'h0000FF);
`else
    chk("box_3_3", 28'(obs_rgb[3][3]), 28'h000000);
    chk("box_35_3", 28'(obs_rgb[35][3]), 28'h000000);
`endif
    en = 1'b0;
    tick();
    chk("en_drop_idle", last_o, IDLE);
    repeat (3) tick();
    en = 1'b1;
    tick();
    chk("reen_fs", 28'({de, frame_start}), 28'b11);
    repeat (100) tick();
    rst = 1'b0;
    #1;
    chk("async_rst", obs(), IDLE);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rst_restart_fs", 28'({de, frame_start}), 28'b11);
    repeat (50) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
